// File: rtl/audio_frame_buffer.sv
// Ping-pong frame collector between the line-in receiver and the analysis path.
// Frames fill one bank while the other is read. Samples that arrive while both banks are held are counted.
module audio_frame_buffer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAME_LEN    = 256,
  parameter int DROP_WIDTH   = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         valid_in,
  input  logic [SAMPLE_WIDTH-1:0]      sample_in,
  output logic                         frame_ready_out,
  output logic                         frame_bank_out,
  input  logic                         rd_en_in,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr_in,
  output logic [SAMPLE_WIDTH-1:0]      rd_data_out,
  output logic                         rd_valid_out,
  input  logic                         frame_done_in,
  output logic                         overflow_out,
  input  logic                         ovf_clear_in,
  output logic [DROP_WIDTH-1:0]        drop_count_out
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  logic [SAMPLE_WIDTH-1:0] mem [2*FRAME_LEN];

  logic                    valid_q, valid_d;
  logic                    wr_bank_q, wr_bank_d;
  logic [AW-1:0]           wr_idx_q, wr_idx_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              bank_full_q, bank_full_d;
  logic                    frame_ready_q, frame_ready_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [SAMPLE_WIDTH-1:0] rd_data_q;
  logic                    accept_s, wr_en_s, drop_s, release_s;
  logic [AW:0]             wr_addr_s, rd_addr_s;

  // Next-state logic. Write/drop decisions use the pre-release bank_full, so a bank
  // freed this cycle only becomes writable from the next one.
  always_comb begin
    valid_d     = valid_in;
    accept_s    = valid_in & ~valid_q;
    wr_en_s     = accept_s & ~bank_full_q[wr_bank_q];
    drop_s      = accept_s & bank_full_q[wr_bank_q];
    release_s   = frame_done_in & frame_ready_q;
    wr_addr_s   = {wr_bank_q, wr_idx_q};
    rd_addr_s   = {rd_bank_q, rd_addr_in};
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    rd_valid_d  = rd_en_in & frame_ready_q;

    if (release_s) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    if (wr_en_s) begin
      if (wr_idx_q == LAST_IDX) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_idx_d               = {AW{1'b0}};
      end else begin
        wr_idx_d = wr_idx_q + AW'(1'b1);
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end

    // Clear takes priority, but a drop in the same cycle is still recorded.
    if (ovf_clear_in) begin
      overflow_d = drop_s;
      drop_cnt_d = drop_s ? DROP_WIDTH'(1'b1) : {DROP_WIDTH{1'b0}};
    end else if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == DROP_MAX) ? DROP_MAX : drop_cnt_q + DROP_WIDTH'(1'b1);
    end else begin
      overflow_d = overflow_q;
    end

    frame_ready_d = bank_full_d[rd_bank_d];
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q       <= 1'b1;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= {AW{1'b0}};
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= {DROP_WIDTH{1'b0}};
      rd_valid_q    <= 1'b0;
      rd_data_q     <= {SAMPLE_WIDTH{1'b0}};
    end else begin
      valid_q       <= valid_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      frame_ready_q <= frame_ready_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_valid_q    <= rd_valid_d;
      if (rd_en_in) begin
        rd_data_q <= mem[rd_addr_s];
      end
    end
  end

  // Sample storage, left unreset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= sample_in;
    end
  end

  assign frame_ready_out = frame_ready_q;
  assign frame_bank_out  = rd_bank_q;
  assign rd_data_out     = rd_data_q;
  assign rd_valid_out    = rd_valid_q;
  assign overflow_out    = overflow_q;
  assign drop_count_out  = drop_cnt_q;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with 4-sample frames and an 8-bit drop counter
// so that counter saturation can be reached within a short run.
module tb_audio_frame_buffer;

  localparam int SW = 24;
  localparam int FL = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [SW-1:0] sample_in;
  logic          frame_ready;
  logic          frame_bank;
  logic          rd_en;
  logic [1:0]    rd_addr;
  logic [SW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_done;
  logic          overflow;
  logic          ovf_clear;
  logic [DW-1:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  audio_frame_buffer #(.SAMPLE_WIDTH(SW), .FRAME_LEN(FL), .DROP_WIDTH(DW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .sample_in(sample_in),
    .frame_ready_out(frame_ready), .frame_bank_out(frame_bank),
    .rd_en_in(rd_en), .rd_addr_in(rd_addr), .rd_data_out(rd_data), .rd_valid_out(rd_valid),
    .frame_done_in(frame_done), .overflow_out(overflow), .ovf_clear_in(ovf_clear),
    .drop_count_out(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s);
    valid_in  = 1'b1;
    sample_in = s;
    repeat (5) tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic pulse();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
  endtask

  task automatic release_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [SW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    check("rd_valid", {31'd0, rd_valid}, 32'd1);
    check("rd_data", {8'd0, rd_data}, {8'd0, exp});
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; sample_in = 24'd0; rd_en = 1'b0; rd_addr = 2'd0;
    frame_done = 1'b0; ovf_clear = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", {31'd0, frame_ready}, 32'd0);
    check("rst_bank", {31'd0, frame_bank}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {8'd0, rd_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drops", {24'd0, drop_count}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // first frame, one write per rising edge
    send(24'd1); send(24'd2); send(24'd3);
    check("ready_after3", {31'd0, frame_ready}, 32'd0);
    send(24'd4);
    check("ready_after4", {31'd0, frame_ready}, 32'd1);
    check("bank_after4", {31'd0, frame_bank}, 32'd0);
    rd(2'd0, 24'd1); rd(2'd1, 24'd2); rd(2'd2, 24'd3); rd(2'd3, 24'd4);
    tick();
    check("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
    check("rd_data_hold", {8'd0, rd_data}, 32'd4);

    // second frame, then both banks held -> drops
    send(24'd5); send(24'd6); send(24'd7); send(24'd8);
    check("ovf_before_drop", {31'd0, overflow}, 32'd0);
    send(24'd9); send(24'd10);
    check("ovf_after_drop", {31'd0, overflow}, 32'd1);
    check("drops_2", {24'd0, drop_count}, 32'd2);
    check("bank_still0", {31'd0, frame_bank}, 32'd0);
    release_frame();
    check("ready_bank1", {31'd0, frame_ready}, 32'd1);
    check("bank_1", {31'd0, frame_bank}, 32'd1);
    rd(2'd0, 24'd5); rd(2'd1, 24'd6); rd(2'd2, 24'd7); rd(2'd3, 24'd8);

    // sample 11 must land in bank 0 index 0
    send(24'd11); send(24'd12); send(24'd13); send(24'd14);
    release_frame();
    check("bank_0_again", {31'd0, frame_bank}, 32'd0);
    rd(2'd0, 24'd11); rd(2'd3, 24'd14);

    // bank 1 completes in the same cycle bank 0 is released
    send(24'd15); send(24'd16); send(24'd17);
    valid_in = 1'b1; sample_in = 24'd18; frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("coinc_ready", {31'd0, frame_ready}, 32'd1);
    check("coinc_bank", {31'd0, frame_bank}, 32'd1);
    repeat (4) tick();
    valid_in = 1'b0;
    tick();
    rd(2'd0, 24'd15); rd(2'd3, 24'd18);
    release_frame();
    check("empty_ready", {31'd0, frame_ready}, 32'd0);
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    check("rd_not_ready", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b0;

    // release while nothing is ready is ignored
    release_frame();
    check("ign_ready", {31'd0, frame_ready}, 32'd0);
    check("ign_bank", {31'd0, frame_bank}, 32'd0);
    send(24'd19); send(24'd20); send(24'd21); send(24'd22);
    check("ign_ready_full", {31'd0, frame_ready}, 32'd1);
    check("ign_bank_full", {31'd0, frame_bank}, 32'd0);

    // reset mid-frame with a read in flight and valid_in held high across release
    send(24'd23);
    valid_in = 1'b1; sample_in = 24'd99; rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_data", {8'd0, rd_data}, 32'd19);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("mid_rst_data", {8'd0, rd_data}, 32'd0);
    check("mid_rst_ready", {31'd0, frame_ready}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_drops", {24'd0, drop_count}, 32'd0);
    rd_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    valid_in = 1'b0;
    tick();
    send(24'd31); send(24'd32); send(24'd33);
    check("restart_ready3", {31'd0, frame_ready}, 32'd0);
    send(24'd34);
    check("restart_ready4", {31'd0, frame_ready}, 32'd1);
    check("restart_bank", {31'd0, frame_bank}, 32'd0);
    rd(2'd0, 24'd31); rd(2'd3, 24'd34);

    // saturating drop counter and clear interactions
    send(24'd35); send(24'd36); send(24'd37); send(24'd38);
    repeat (259) pulse();
    check("sat_drops", {24'd0, drop_count}, 32'hFF);
    check("sat_ovf", {31'd0, overflow}, 32'd1);
    valid_in = 1'b1; ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0; valid_in = 1'b0;
    check("clr_drop_ovf", {31'd0, overflow}, 32'd1);
    check("clr_drop_cnt", {24'd0, drop_count}, 32'd1);
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    check("clr_cnt", {24'd0, drop_count}, 32'd0);

    // release and drop in the same cycle: sample still lost
    valid_in = 1'b1; sample_in = 24'd77; frame_done = 1'b1;
    tick();
    frame_done = 1'b0; valid_in = 1'b0;
    check("reldrop_cnt", {24'd0, drop_count}, 32'd1);
    check("reldrop_bank", {31'd0, frame_bank}, 32'd1);
    check("reldrop_ready", {31'd0, frame_ready}, 32'd1);
    tick();
    rd(2'd2, 24'd37);
    send(24'd40); send(24'd41); send(24'd42); send(24'd43);
    check("reldrop_cnt_hold", {24'd0, drop_count}, 32'd1);
    release_frame();
    check("final_bank", {31'd0, frame_bank}, 32'd0);
    rd(2'd0, 24'd40); rd(2'd1, 24'd41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
